// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared RV32I decode types and constants (package defs)
package defs;

  localparam int XLEN          = 32;
  localparam int RF_PNTR_WIDTH = 5;

  localparam logic [6:0] OP_AL_R     = 7'b0110011;
  localparam logic [6:0] OP_AL_I     = 7'b0010011;
  localparam logic [6:0] OP_AL_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AL_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_AL_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AL_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AL_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_FENCE    = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNC3_SLL     = 3'b001;
  localparam logic [2:0] FUNC3_SLT     = 3'b010;
  localparam logic [2:0] FUNC3_SLTU    = 3'b011;
  localparam logic [2:0] FUNC3_XOR     = 3'b100;
  localparam logic [2:0] FUNC3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNC3_OR      = 3'b110;
  localparam logic [2:0] FUNC3_AND     = 3'b111;
  localparam logic [2:0] FUNC3_BEQ     = 3'b000;
  localparam logic [2:0] FUNC3_BNE     = 3'b001;
  localparam logic [2:0] FUNC3_BLT     = 3'b100;
  localparam logic [2:0] FUNC3_BGE     = 3'b101;
  localparam logic [2:0] FUNC3_BLTU    = 3'b110;
  localparam logic [2:0] FUNC3_BGEU    = 3'b111;

  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_OP_ADD     = 4'd0,
    ALU_OP_SUB     = 4'd1,
    ALU_OP_SLL     = 4'd2,
    ALU_OP_SLT     = 4'd3,
    ALU_OP_SLTU    = 4'd4,
    ALU_OP_XOR     = 4'd5,
    ALU_OP_SRL     = 4'd6,
    ALU_OP_SRA     = 4'd7,
    ALU_OP_OR      = 4'd8,
    ALU_OP_AND     = 4'd9,
    ALU_OP_INVALID = 4'd15
  } alu_op_type;

  typedef enum logic [2:0] {
    ALU_IN_REG   = 3'd0,
    ALU_IN_IMM   = 3'd1,
    ALU_IN_PC    = 3'd2,
    ALU_IN_SHAMT = 3'd3,
    ALU_IN_NULL  = 3'd4
  } alu_in_type;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type;

  typedef struct packed {
    alu_op_type               alu_op;
    alu_in_type               src_a;
    alu_in_type               src_b;
    logic [RF_PNTR_WIDTH-1:0] rs1;
    logic [RF_PNTR_WIDTH-1:0] rs2;
    logic [RF_PNTR_WIDTH-1:0] rd;
    logic                     rd_we;
    logic [XLEN-1:0]          imm;
    logic [XLEN-1:0]          pc;
    logic [2:0]               func3;
    logic                     is_branch;
    logic                     is_jump;
    logic                     illegal;
  } dec_ctrl_t;

  // alt selects the func7[5] variant (SUB/SRA) on the two func3 codes that have one
  function automatic alu_op_type alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      FUNC3_ADD_SUB: return alt ? ALU_OP_SUB : ALU_OP_ADD;
      FUNC3_SLL:     return ALU_OP_SLL;
      FUNC3_SLT:     return ALU_OP_SLT;
      FUNC3_SLTU:    return ALU_OP_SLTU;
      FUNC3_XOR:     return ALU_OP_XOR;
      FUNC3_SRL_SRA: return alt ? ALU_OP_SRA : ALU_OP_SRL;
      FUNC3_OR:      return ALU_OP_OR;
      default:       return ALU_OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle of decode_stage
interface decode_stage_if;
  import defs::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_instr;
  logic [XLEN-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_alu_op;
  logic [2:0]               out_src_a;
  logic [2:0]               out_src_b;
  logic [RF_PNTR_WIDTH-1:0] out_rs1;
  logic [RF_PNTR_WIDTH-1:0] out_rs2;
  logic [RF_PNTR_WIDTH-1:0] out_rd;
  logic                     out_rd_we;
  logic [XLEN-1:0]          out_imm;
  logic [XLEN-1:0]          out_pc;
  logic [2:0]               out_func3;
  logic                     out_is_branch;
  logic                     out_is_jump;
  logic                     out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_src_a, out_src_b, out_rs1, out_rs2, out_rd,
           out_rd_we, out_imm, out_pc, out_func3, out_is_branch, out_is_jump, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_src_a, out_src_b, out_rs1, out_rs2, out_rd,
           out_rd_we, out_imm, out_pc, out_func3, out_is_branch, out_is_jump, out_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - sign-extended RV32I immediate extraction (imm_gen)
module imm_gen
  import defs::*;
(
  input  logic [31:7]     i_instr,
  input  imm_type         i_imm_type,
  output logic [XLEN-1:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_imm_type)
      IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   o_imm = {i_instr[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with 2-entry skid buffer
// Optional DECODE_PERF_CNT_EN adds output-transfer and illegal-transfer counters.
module decode_stage
  import defs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]   out_decoded_cnt,
  output logic [31:0]   out_illegal_cnt
`endif
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  imm_type         w_imm_type;
  logic [XLEN-1:0] w_imm;
  dec_ctrl_t       w_dec;
  logic            w_legal;
  logic            w_wr;
  logic            w_accept;
  logic            w_drain;

  dec_ctrl_t       r_out;
  dec_ctrl_t       r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;

  assign w_opcode = bus.in_instr[6:0];
  assign w_f3     = bus.in_instr[14:12];
  assign w_f7     = bus.in_instr[31:25];
  assign w_rd     = bus.in_instr[11:7];

  always_comb begin
    case (w_opcode)
      OP_AL_B:                w_imm_type = IMM_B;
      OP_AL_LUI, OP_AL_AUIPC: w_imm_type = IMM_U;
      OP_AL_JAL:              w_imm_type = IMM_J;
      OP_STORE:               w_imm_type = IMM_S;
      default:                w_imm_type = IMM_I;
    endcase
  end

  imm_gen u_imm_gen (
    .i_instr    (bus.in_instr[31:7]),
    .i_imm_type (w_imm_type),
    .o_imm      (w_imm)
  );

  always_comb begin
    w_dec       = '0;
    w_dec.pc    = bus.in_pc;
    w_dec.func3 = w_f3;
    w_dec.rs1   = bus.in_instr[19:15];
    w_dec.rd    = w_rd;
    w_dec.imm   = w_imm;
    w_legal     = 1'b1;
    w_wr        = 1'b1;
    case (w_opcode)
      OP_AL_R: begin
        w_legal = (w_f7 == FUNC7_BASE) ||
                  ((w_f7 == FUNC7_ALT) && ((w_f3 == FUNC3_ADD_SUB) || (w_f3 == FUNC3_SRL_SRA)));
        w_dec.alu_op = alu_op_from_f3(w_f3, w_f7[5]);
        w_dec.rs2    = bus.in_instr[24:20];
        w_dec.imm    = '0;
      end
      OP_AL_I: begin
        if ((w_f3 == FUNC3_SLL) || (w_f3 == FUNC3_SRL_SRA)) begin
          w_legal = (w_f7 == FUNC7_BASE) || ((w_f7 == FUNC7_ALT) && (w_f3 == FUNC3_SRL_SRA));
          w_dec.alu_op = alu_op_from_f3(w_f3, w_f7[5]);
          w_dec.src_b  = ALU_IN_SHAMT;
          w_dec.imm    = {27'b0, bus.in_instr[24:20]};
        end else begin
          w_dec.alu_op = alu_op_from_f3(w_f3, 1'b0);
          w_dec.src_b  = ALU_IN_IMM;
        end
      end
      OP_AL_LUI: begin
        w_dec.src_a = ALU_IN_NULL;
        w_dec.src_b = ALU_IN_IMM;
      end
      OP_AL_AUIPC, OP_AL_JAL: begin
        w_dec.src_a   = ALU_IN_PC;
        w_dec.src_b   = ALU_IN_IMM;
        w_dec.is_jump = (w_opcode == OP_AL_JAL);
      end
      OP_AL_JALR: begin
        w_dec.src_b   = ALU_IN_IMM;
        w_dec.is_jump = 1'b1;
      end
      OP_AL_B: begin
        w_wr            = 1'b0;
        w_dec.is_branch = 1'b1;
        w_dec.rs2       = bus.in_instr[24:20];
        case (w_f3)
          FUNC3_BEQ, FUNC3_BNE:   w_dec.alu_op = ALU_OP_SUB;
          FUNC3_BLT, FUNC3_BGE:   w_dec.alu_op = ALU_OP_SLT;
          FUNC3_BLTU, FUNC3_BGEU: w_dec.alu_op = ALU_OP_SLTU;
          default:                w_legal      = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE, OP_FENCE, OP_SYSTEM: w_legal = 1'b0;
      default:                                w_legal = 1'b0;
    endcase
    // Illegal entries still travel the pipe but carry no side effects
    if (!w_legal) begin
      w_dec.alu_op    = ALU_OP_INVALID;
      w_dec.src_a     = ALU_IN_NULL;
      w_dec.src_b     = ALU_IN_NULL;
      w_dec.rs1       = '0;
      w_dec.rs2       = '0;
      w_dec.rd        = '0;
      w_dec.imm       = '0;
      w_dec.is_branch = 1'b0;
      w_dec.is_jump   = 1'b0;
      w_dec.rd_we     = 1'b0;
      w_dec.illegal   = 1'b1;
    end else begin
      w_dec.rd_we = w_wr && (w_rd != 5'd0);
    end
  end

  assign w_accept = bus.in_valid && !r_skid_valid && !flush;
  assign w_drain  = r_out_valid && bus.out_ready;

  // Skid entry is only ever occupied behind a full, stalled output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_drain) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready      = !r_skid_valid;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_alu_op    = r_out.alu_op;
  assign bus.out_src_a     = r_out.src_a;
  assign bus.out_src_b     = r_out.src_b;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_rd_we     = r_out.rd_we;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_pc        = r_out.pc;
  assign bus.out_func3     = r_out.func3;
  assign bus.out_is_branch = r_out.is_branch;
  assign bus.out_is_jump   = r_out.is_jump;
  assign bus.out_illegal   = r_out.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_decoded_cnt;
  logic [31:0] r_illegal_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_decoded_cnt <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_drain)                 r_decoded_cnt <= r_decoded_cnt + 32'd1;
      if (w_drain && r_out.illegal) r_illegal_cnt <= r_illegal_cnt + 32'd1;
    end
  end

  assign out_decoded_cnt = r_decoded_cnt;
  assign out_illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a queue-based reference
module tb_decode_stage;
  import defs::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  decode_stage_if bus ();

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] dec_cnt;
  logic [31:0] ill_cnt;
  int          m_dec = 0;
  int          m_ill = 0;
`endif

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef DECODE_PERF_CNT_EN
    ,
    .out_decoded_cnt (dec_cnt),
    .out_illegal_cnt (ill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam alu_op_type ALU_MAP [0:7] = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
                                           ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
  localparam alu_op_type BR_MAP [0:7]  = '{ALU_OP_SUB, ALU_OP_SUB, ALU_OP_INVALID, ALU_OP_INVALID,
                                           ALU_OP_SLT, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_SLTU};
  localparam logic [6:0] OPS [0:11]    = '{OP_AL_R, OP_AL_I, OP_AL_I, OP_AL_R, OP_AL_LUI, OP_AL_AUIPC,
                                           OP_AL_JAL, OP_AL_JALR, OP_AL_B, OP_LOAD, OP_SYSTEM, 7'h7F};

  dec_ctrl_t q[$];
  dec_ctrl_t shown;
  bit        idle_known;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic dec_ctrl_t observed();
    dec_ctrl_t o;
    o.alu_op    = alu_op_type'(bus.out_alu_op);
    o.src_a     = alu_in_type'(bus.out_src_a);
    o.src_b     = alu_in_type'(bus.out_src_b);
    o.rs1       = bus.out_rs1;
    o.rs2       = bus.out_rs2;
    o.rd        = bus.out_rd;
    o.rd_we     = bus.out_rd_we;
    o.imm       = bus.out_imm;
    o.pc        = bus.out_pc;
    o.func3     = bus.out_func3;
    o.is_branch = bus.out_is_branch;
    o.is_jump   = bus.out_is_jump;
    o.illegal   = bus.out_illegal;
    return o;
  endfunction

  function automatic dec_ctrl_t model(input logic [31:0] ins, input logic [31:0] pc);
    dec_ctrl_t  e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit         ok = 1'b1;
    bit         writes = 1'b1;
    int         b_imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    int         j_imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    e       = '0;
    e.pc    = pc;
    e.func3 = f3;
    e.rs1   = ins[19:15];
    e.rd    = ins[11:7];
    if (op == OP_AL_R) begin
      ok = (f7 == 7'd0) || (f7 == FUNC7_ALT && (f3 == 3'd0 || f3 == 3'd5));
      e.alu_op = (f7 == FUNC7_ALT && f3 == 3'd0) ? ALU_OP_SUB :
                 (f7 == FUNC7_ALT && f3 == 3'd5) ? ALU_OP_SRA : ALU_MAP[f3];
      e.rs2 = ins[24:20];
    end else if (op == OP_AL_I) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        ok = (f7 == 7'd0) || (f7 == FUNC7_ALT && f3 == 3'd5);
        e.alu_op = (f7 == FUNC7_ALT && f3 == 3'd5) ? ALU_OP_SRA : ALU_MAP[f3];
        e.src_b  = ALU_IN_SHAMT;
        e.imm    = 32'(ins[24:20]);
      end else begin
        e.alu_op = ALU_MAP[f3];
        e.src_b  = ALU_IN_IMM;
        e.imm    = 32'($signed(ins) >>> 20);
      end
    end else if (op == OP_AL_LUI || op == OP_AL_AUIPC) begin
      e.src_a = (op == OP_AL_LUI) ? ALU_IN_NULL : ALU_IN_PC;
      e.src_b = ALU_IN_IMM;
      e.imm   = ins & 32'hFFFF_F000;
    end else if (op == OP_AL_JAL) begin
      e.src_a   = ALU_IN_PC;
      e.src_b   = ALU_IN_IMM;
      e.imm     = 32'(j_imm);
      e.is_jump = 1'b1;
    end else if (op == OP_AL_JALR) begin
      e.src_b   = ALU_IN_IMM;
      e.imm     = 32'($signed(ins) >>> 20);
      e.is_jump = 1'b1;
    end else if (op == OP_AL_B) begin
      ok          = (f3 != 3'd2) && (f3 != 3'd3);
      e.alu_op    = BR_MAP[f3];
      e.rs2       = ins[24:20];
      e.imm       = 32'(b_imm);
      e.is_branch = 1'b1;
      writes      = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      e         = '0;
      e.pc      = pc;
      e.func3   = f3;
      e.alu_op  = ALU_OP_INVALID;
      e.src_a   = ALU_IN_NULL;
      e.src_b   = ALU_IN_NULL;
      e.illegal = 1'b1;
    end else begin
      e.rd_we = writes && (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    int          k = $urandom_range(0, 9);
    r[6:0] = OPS[$urandom_range(0, 11)];
    if (k < 5)      r[31:25] = 7'd0;
    else if (k < 8) r[31:25] = FUNC7_ALT;
    return r;
  endfunction

  // One cycle: compare current outputs with the model, then advance the model across the edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl, input logic rs);
    bit acc;
    bit drn;
    bit had;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    rst_n         = rs;
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
    if (q.size() > 0)   chk("out_fields", 128'(observed()), 128'(q[0]));
    else if (idle_known) chk("held_fields", 128'(observed()), 128'(shown));
`ifdef DECODE_PERF_CNT_EN
    chk("decoded_cnt", 128'(dec_cnt), 128'(32'(m_dec)));
    chk("illegal_cnt", 128'(ill_cnt), 128'(32'(m_ill)));
`endif
    acc = v && (q.size() < 2) && !fl;
    drn = (q.size() > 0) && rdy;
    had = q.size() > 0;
    @(posedge clk);
    #1;
    if (!rs) begin
      q.delete();
      shown      = '0;
      idle_known = 1'b1;
`ifdef DECODE_PERF_CNT_EN
      m_dec = 0;
      m_ill = 0;
`endif
    end else begin
      if (drn) begin
`ifdef DECODE_PERF_CNT_EN
        m_dec++;
        if (q[0].illegal) m_ill++;
`endif
        void'(q.pop_front());
      end
      if (fl) begin
        q.delete();
        idle_known = idle_known || had;
      end else begin
        if (acc) q.push_back(model(ins, pc));
        if (q.size() > 0) shown = q[0];
        else if (drn)     idle_known = 1'b0;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    shown      = '0;
    idle_known = 1'b1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("rst_fields", 128'(observed()), 128'(0));

    step(1'b1, 32'h0050_0093, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    chk("addi_valid", 128'(bus.out_valid), 128'(1'b1));
    chk("addi_imm", 128'(bus.out_imm), 128'(32'd5));
    chk("addi_op", 128'(bus.out_alu_op), 128'(ALU_OP_ADD));
    chk("addi_srcb", 128'(bus.out_src_b), 128'(ALU_IN_IMM));
    chk("addi_rd_we", 128'({bus.out_rd, bus.out_rd_we}), 128'({5'd1, 1'b1}));

    step(1'b1, 32'h4030_D113, 32'h0000_0004, 1'b1, 1'b0, 1'b1);
    chk("srai_op", 128'(bus.out_alu_op), 128'(ALU_OP_SRA));
    chk("srai_srcb_imm", 128'({bus.out_src_b, bus.out_imm}), 128'({ALU_IN_SHAMT, 32'd3}));

    step(1'b1, 32'h4020_81B3, 32'h0000_0008, 1'b1, 1'b0, 1'b1);
    chk("sub_op", 128'({bus.out_alu_op, bus.out_src_b}), 128'({ALU_OP_SUB, ALU_IN_REG}));

    step(1'b1, 32'hFE20_CCE3, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
    chk("blt_op", 128'({bus.out_alu_op, bus.out_is_branch, bus.out_rd_we}), 128'({ALU_OP_SLT, 1'b1, 1'b0}));
    chk("blt_imm", 128'(bus.out_imm), 128'(32'hFFFF_FFF8));
    chk("blt_pc_f3", 128'({bus.out_pc, bus.out_func3}), 128'({32'h0000_0100, 3'd4}));

    step(1'b1, 32'h0000_0003, 32'h0000_0104, 1'b1, 1'b0, 1'b1);
    chk("illegal", 128'({bus.out_illegal, bus.out_alu_op, bus.out_rd_we}), 128'({1'b1, ALU_OP_INVALID, 1'b0}));

    step(1'b1, 32'h0020_8033, 32'h0000_0108, 1'b1, 1'b0, 1'b1);
    chk("add_x0", 128'({bus.out_alu_op, bus.out_rd_we}), 128'({ALU_OP_ADD, 1'b0}));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    step(1'b1, 32'h0010_0093, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0020_0113, 32'h0000_0204, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0030_0193, 32'h0000_0208, 1'b0, 1'b0, 1'b1);
    chk("bp_in_ready", 128'({bus.in_ready, bus.out_pc}), 128'({1'b0, 32'h0000_0200}));
    step(1'b1, 32'h0030_0193, 32'h0000_0208, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0030_0193, 32'h0000_0208, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    step(1'b1, 32'h0010_0093, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0020_0113, 32'h0000_0304, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0030_0193, 32'h0000_0308, 1'b0, 1'b1, 1'b1);
    chk("flush_state", 128'({bus.out_valid, bus.in_ready}), 128'({1'b0, 1'b1}));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    step(1'b1, 32'h0010_0093, 32'h0000_0400, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0020_0113, 32'h0000_0404, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0030_0193, 32'h0000_0408, 1'b0, 1'b0, 1'b0);
    chk("midstall_rst", 128'({bus.out_valid, bus.in_ready, observed()}), 128'({1'b0, 1'b1, 96'd0}));

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, gen_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 99) != 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
